mmio_bus_master: RTL and testbench

MMIO_BUS_MASTER -- requirements
Module: mmio_bus_master

---
 rtl/mmio_bus_master_if.sv | 33 +++
 rtl/mmio_bus_master.sv | 156 +++++++++++++++
 tb/tb_mmio_bus_master.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_master_if.sv
// CPU request/response channel plus the peripheral strobe bus.
// master = the bus master's view, slave = the CPU/peripheral side.
interface mmio_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        AS_L;
  logic        WE_L;
  logic [7:0]  sel;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  rsp_ready, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output AS_L, WE_L, sel, bus_addr, bus_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output rsp_ready, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  AS_L, WE_L, sel, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mmio_bus_master.sv
// Strobed MMIO bus master: turns CPU requests into
// setup / strobe / hold peripheral cycles, all outputs registered.
module mmio_bus_master #(
  parameter logic [15:0] IO_BASE     = 16'hF000,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic              clk,
  input logic              reset_n,
  mmio_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  localparam logic [4:0] WS5 = 5'(WAIT_STATES);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;
  logic        r_as_l;
  logic        r_we_l;
  logic [7:0]  r_sel;
  logic [7:0]  r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [4:0]  r_cnt;

  state_t      w_state;
  logic        w_req_ready;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_error;
  logic        w_as_l;
  logic        w_we_l;
  logic [7:0]  w_sel;
  logic [7:0]  w_bus_addr;
  logic [31:0] w_bus_wdata;
  logic [4:0]  w_cnt;
  logic        w_hs;
  logic        w_legal;

  // Next state and next value of every registered output.
  always_comb begin
    w_state     = r_state;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_error = r_rsp_error;
    w_as_l      = r_as_l;
    w_we_l      = r_we_l;
    w_sel       = r_sel;
    w_bus_addr  = r_bus_addr;
    w_bus_wdata = r_bus_wdata;
    w_cnt       = r_cnt;
    w_hs        = bus.req_valid & r_req_ready;
    w_legal     = (bus.req_addr[31:16] == IO_BASE)
                & (bus.req_addr[1:0] == 2'b00)
                & ~bus.req_addr[15];
    unique case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_rsp_rdata = '0;
          if (w_legal) begin
            w_state     = S_SETUP;
            w_sel       = 8'b1 << bus.req_addr[14:12];
            w_bus_addr  = bus.req_addr[9:2];
            w_bus_wdata = bus.req_wdata;
            w_we_l      = ~bus.req_write;
            w_rsp_error = 1'b0;
          end else begin
            w_state     = S_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_error = 1'b1;
          end
        end
      end
      S_SETUP: begin
        w_state = S_STROBE;
        w_as_l  = 1'b0;
        w_cnt   = WS5;
      end
      S_STROBE: begin
        if (r_cnt == 5'd0) begin
          w_state     = S_HOLD;
          w_as_l      = 1'b1;
          w_rsp_rdata = r_we_l ? bus.bus_rdata : '0;
        end else begin
          w_cnt = r_cnt - 5'd1;
        end
      end
      S_HOLD: begin
        w_state     = S_RESP;
        w_sel       = '0;
        w_we_l      = 1'b1;
        w_rsp_valid = 1'b1;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state     = S_IDLE;
          w_rsp_valid = 1'b0;
          w_rsp_rdata = '0;
          w_rsp_error = 1'b0;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_req_ready = (w_state == S_IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_as_l      <= 1'b1;
      r_we_l      <= 1'b1;
      r_sel       <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_error <= w_rsp_error;
      r_as_l      <= w_as_l;
      r_we_l      <= w_we_l;
      r_sel       <= w_sel;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
      r_cnt       <= w_cnt;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_error = r_rsp_error;
  assign bus.AS_L      = r_as_l;
  assign bus.WE_L      = r_we_l;
  assign bus.sel       = r_sel;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mmio_bus_master.sv
// Bench for mmio_bus_master: WAIT_STATES=1 and =0 builds share
// stimulus and are checked every cycle against a timeline model.
module tb_mmio_bus_master;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic        rsp_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem [8][256];

  int n_vec = 0;
  int n_err = 0;

  bit          m_busy  [2];
  int          m_k     [2];
  bit          m_legal [2];
  bit          m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rexp  [2];

  mmio_bus_master_if bus0 ();
  mmio_bus_master_if bus1 ();

  function automatic logic [31:0] periph(input logic [7:0] s,
                                         input logic [7:0] a);
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++)
      if (s == (8'd1 << i)) v = mem[i][a];
    return v;
  endfunction

  assign bus0.req_valid = req_valid;
  assign bus0.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus0.rsp_ready = rsp_ready;
  assign bus0.bus_rdata = periph(bus0.sel, bus0.bus_addr);
  assign bus1.req_valid = req_valid;
  assign bus1.req_write = req_write;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.rsp_ready = rsp_ready;
  assign bus1.bus_rdata = periph(bus1.sel, bus1.bus_addr);

  mmio_bus_master #(.IO_BASE(16'hF000), .WAIT_STATES(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.master)
  );
  mmio_bus_master #(.IO_BASE(16'hF000), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit legal_addr(input logic [31:0] a);
    return a[31:16] == 16'hF000 && a[1:0] == 2'b00 && a[15] == 1'b0;
  endfunction

  function automatic bit in_resp(input int d);
    return m_legal[d] ? (m_k[d] >= ws(d) + 4) : (m_k[d] >= 1);
  endfunction

  task automatic advance(input int d);
    if (!reset_n) begin
      m_busy[d] = 1'b0;
    end else if (!m_busy[d]) begin
      if (req_valid) begin
        m_busy[d]  = 1'b1;
        m_k[d]     = 1;
        m_legal[d] = legal_addr(req_addr);
        m_wr[d]    = req_write;
        m_addr[d]  = req_addr;
        m_wdata[d] = req_wdata;
        m_rexp[d]  = (m_legal[d] && !req_write)
                   ? mem[req_addr[14:12]][req_addr[9:2]] : 32'h0;
      end
    end else if (in_resp(d) && rsp_ready) begin
      m_busy[d] = 1'b0;
    end else begin
      m_k[d]++;
    end
  endtask

  task automatic check_outs(input int d, input logic rr,
                            input logic rv, input logic [31:0] rd,
                            input logic re, input logic as_l,
                            input logic we_l, input logic [7:0] sel,
                            input logic [7:0] ba,
                            input logic [31:0] bw);
    string p;
    int k;
    p = $sformatf("d%0d", d);
    k = m_k[d];
    if (!m_busy[d]) begin
      chk({p, ".req_ready"}, rr, 1);
      chk({p, ".rsp_valid"}, rv, 0);
      chk({p, ".AS_L"}, as_l, 1);
      chk({p, ".WE_L"}, we_l, 1);
      chk({p, ".sel"}, sel, 0);
    end else if (m_legal[d] && k <= ws(d) + 3) begin
      chk({p, ".req_ready"}, rr, 0);
      chk({p, ".rsp_valid"}, rv, 0);
      chk({p, ".sel"}, sel, 8'd1 << m_addr[d][14:12]);
      chk({p, ".bus_addr"}, ba, m_addr[d][9:2]);
      chk({p, ".bus_wdata"}, bw, m_wdata[d]);
      chk({p, ".WE_L"}, we_l, !m_wr[d]);
      chk({p, ".AS_L"}, as_l,
          (k >= 2 && k <= ws(d) + 2) ? 0 : 1);
    end else begin
      chk({p, ".req_ready"}, rr, 0);
      chk({p, ".rsp_valid"}, rv, 1);
      chk({p, ".rsp_rdata"}, rd, m_rexp[d]);
      chk({p, ".rsp_error"}, re, !m_legal[d]);
      chk({p, ".AS_L"}, as_l, 1);
      chk({p, ".WE_L"}, we_l, 1);
      chk({p, ".sel"}, sel, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    advance(0);
    advance(1);
    @(negedge clk);
    check_outs(0, bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata,
               bus0.rsp_error, bus0.AS_L, bus0.WE_L, bus0.sel,
               bus0.bus_addr, bus0.bus_wdata);
    check_outs(1, bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata,
               bus1.rsp_error, bus1.AS_L, bus1.WE_L, bus1.sel,
               bus1.bus_addr, bus1.bus_wdata);
  endtask

  task automatic rst_vals(input string p, input logic rr,
                          input logic rv, input logic [31:0] rd,
                          input logic re, input logic as_l,
                          input logic we_l, input logic [7:0] sel,
                          input logic [7:0] ba,
                          input logic [31:0] bw);
    chk({p, ".rst.req_ready"}, rr, 1);
    chk({p, ".rst.rsp_valid"}, rv, 0);
    chk({p, ".rst.rsp_rdata"}, rd, 0);
    chk({p, ".rst.rsp_error"}, re, 0);
    chk({p, ".rst.AS_L"}, as_l, 1);
    chk({p, ".rst.WE_L"}, we_l, 1);
    chk({p, ".rst.sel"}, sel, 0);
    chk({p, ".rst.bus_addr"}, ba, 0);
    chk({p, ".rst.bus_wdata"}, bw, 0);
  endtask

  task automatic rst_both();
    rst_vals("d0", bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata,
             bus0.rsp_error, bus0.AS_L, bus0.WE_L, bus0.sel,
             bus0.bus_addr, bus0.bus_wdata);
    rst_vals("d1", bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata,
             bus1.rsp_error, bus1.AS_L, bus1.WE_L, bus1.sel,
             bus1.bus_addr, bus1.bus_wdata);
  endtask

  task automatic run_req(input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input int e0,
                         input int e1);
    int lat0;
    int lat1;
    int i;
    lat0 = -1;
    lat1 = -1;
    req_addr  = a;
    req_write = w;
    req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    i = 1;
    while ((m_busy[0] || m_busy[1]) && i < 40) begin
      if (bus0.rsp_valid && lat0 < 0) lat0 = i;
      if (bus1.rsp_valid && lat1 < 0) lat1 = i;
      tick();
      i++;
    end
    chk($sformatf("lat.d0@%h", a), lat0, e0);
    chk($sformatf("lat.d1@%h", a), lat1, e1);
  endtask

  function automatic logic [31:0] gen_addr();
    logic [31:0] a;
    int kind;
    kind = $urandom_range(0, 7);
    a = {16'hF000, 1'b0, 3'($urandom_range(0, 7)),
         2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
         2'b00};
    if (kind == 0) begin
      a[31:16] = 16'($urandom);
      if (a[31:16] == 16'hF000) a[31] = 1'b0;
    end else if (kind == 1) begin
      a[1:0] = 2'($urandom_range(1, 3));
    end else if (kind == 2) begin
      a[15] = 1'b1;
    end
    return a;
  endfunction

  initial begin
    int i;
    for (int p = 0; p < 8; p++)
      for (int r = 0; r < 256; r++)
        mem[p][r] = $urandom;
    mem[0][0] = 32'h0000_1234;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_k[d]    = 0;
    end
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    rsp_ready = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    @(negedge clk);
    rst_both();
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    run_req(32'hF000_1004, 1'b1, 32'h3, 5, 4);
    run_req(32'hF000_0000, 1'b0, $urandom, 5, 4);
    run_req(32'h1000_0000, 1'b0, $urandom, 1, 1);
    run_req(32'hF000_0002, 1'b0, $urandom, 1, 1);
    run_req(32'hF000_7000, 1'b0, $urandom, 5, 4);

    req_addr  = 32'hF000_2010;
    req_write = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    tick();
    for (int c = 0; c < 14; c++) begin
      req_addr  = gen_addr();
      req_write = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      tick();
    end
    chk("stall.d0.rsp_valid", bus0.rsp_valid, 1);
    chk("stall.d1.rsp_valid", bus1.rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    run_req(32'hF000_3020, 1'b0, $urandom, 5, 4);

    req_addr  = 32'hF000_4008;
    req_write = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre.d0.AS_L", bus0.AS_L, 0);
    chk("pre.d1.AS_L", bus1.AS_L, 0);
    #2 reset_n = 1'b0;
    #1;
    m_busy[0] = 1'b0;
    m_busy[1] = 1'b0;
    chk("arst.d0.AS_L", bus0.AS_L, 1);
    chk("arst.d0.sel", bus0.sel, 0);
    chk("arst.d1.AS_L", bus1.AS_L, 1);
    chk("arst.d1.sel", bus1.sel, 0);
    tick();
    rst_both();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    run_req(32'hF000_5100, 1'b1, $urandom, 5, 4);

    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      req_addr  = gen_addr();
      req_write = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    i = 0;
    while ((m_busy[0] || m_busy[1]) && i < 40) begin
      tick();
      i++;
    end
    chk("drain.d0.req_ready", bus0.req_ready, 1);
    chk("drain.d1.req_ready", bus1.req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
